// File: rtl/enm_fire_sched.sv
// Enemy fire scheduler: waits a programmable period, then picks the next
// alive enemy with no bullet in flight (round-robin) and issues a one-cycle
// one-hot launch pulse to the bullet datapath.
//
// Ports:
//   clk22      in   clock, all state updates on its rising edge
//   rst        in   synchronous active-low reset
//   gamestart  in   synchronous clear, same effect as reset
//   enm[3:0]   in   per-enemy alive flags (bit i = enemy i+1)
//   busy[3:0]  in   per-enemy bullet-in-flight flags
//   interval   in   fire period select, sampled at every timer reload
//   fire[3:0]  out  one-hot, one-cycle launch pulse
//   fire_id    out  index of the last enemy fired, held until the next fire
//   active     out  high whenever the scheduler is not idle
//   shots[7:0] out  fire pulse count, saturating at 255
//
// Optional feature: define ENM_FIRE_JITTER_EN to randomise the low nibble of
// the reload value with an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5).
module enm_fire_sched (
  input  logic       clk22,
  input  logic       rst,
  input  logic       gamestart,
  input  logic [3:0] enm,
  input  logic [3:0] busy,
  input  logic [3:0] interval,
  output logic [3:0] fire,
  output logic [1:0] fire_id,
  output logic       active,
  output logic [7:0] shots
);

  localparam int unsigned N_ENM  = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned TMR_W  = 8;
  localparam int unsigned SHOT_W = 8;

  typedef enum logic [1:0] {IDLE, COUNT, SELECT, FIRE} state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n, reload;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [N_ENM-1:0]   fire_n;
  logic [ID_W-1:0]    fire_id_n;
  logic [SHOT_W-1:0]  shots_n;
  logic               found;
  logic [ID_W-1:0]    cand;

  wire sync_clr = !rst || gamestart;

`ifdef ENM_FIRE_JITTER_EN
  logic [7:0] lfsr;
  logic [7:0] reload_raw;

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk22) begin
    if (sync_clr) lfsr <= 8'hA5;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // A zero reload would make COUNT collapse; clamp to the shortest legal period
  always_comb begin
    reload_raw = {interval, lfsr[3:0]};
    reload     = (reload_raw == '0) ? TMR_W'(1) : reload_raw;
  end
`else
  assign reload = {interval, 4'hF};
`endif

  // Round-robin scan starting one past the last fired enemy; k = N_ENM wraps to ptr itself
  always_comb begin
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_ENM; k++) begin
      if (!found && enm[ptr + ID_W'(k)] && !busy[ptr + ID_W'(k)]) begin
        found = 1'b1;
        cand  = ptr + ID_W'(k);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    ptr_n     = ptr;
    fire_n    = '0;
    fire_id_n = fire_id;
    shots_n   = shots;
    unique case (state)
      IDLE: begin
        if (enm != '0) begin
          state_n = COUNT;
          timer_n = reload;
        end
      end
      COUNT: begin
        if (enm == '0)          state_n = IDLE;
        else if (timer == '0)   state_n = SELECT;
        else                    timer_n = timer - TMR_W'(1);
      end
      SELECT: begin
        if (enm == '0) begin
          state_n = IDLE;
        end else if (found) begin
          // Pulse and count are registered on entry so they appear during FIRE
          state_n   = FIRE;
          ptr_n     = cand;
          fire_id_n = cand;
          fire_n    = N_ENM'(1) << cand;
          if (shots != '1) shots_n = shots + SHOT_W'(1);
        end
      end
      FIRE: begin
        timer_n = reload;
        state_n = (enm == '0) ? IDLE : COUNT;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk22) begin
    if (sync_clr) begin
      state   <= IDLE;
      timer   <= '0;
      ptr     <= ID_W'(N_ENM - 1);
      fire    <= '0;
      fire_id <= '0;
      active  <= 1'b0;
      shots   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      ptr     <= ptr_n;
      fire    <= fire_n;
      fire_id <= fire_id_n;
      active  <= (state_n != IDLE);
      shots   <= shots_n;
    end
  end

endmodule
